// File: rtl/instr_fetch_buffer_if.sv
// Decode-side handshake of the instruction fetch buffer.
// The fetch buffer drives the queue head (master); decode consumes it (slave).
interface instr_fetch_buffer_if #(
    parameter int PC_W = 8
);
    logic            dec_valid;
    logic            dec_ready;
    logic [31:0]     dec_instr;
    logic [PC_W-1:0] dec_pc;

    modport master (
        output dec_valid,
        output dec_instr,
        output dec_pc,
        input  dec_ready
    );

    modport slave (
        input  dec_valid,
        input  dec_instr,
        input  dec_pc,
        output dec_ready
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer.
// Issues one-word requests to a sequential instruction memory, captures each
// returned word one cycle later, tags it with its byte PC and queues it in a
// small FIFO that decode drains through a valid/ready handshake. Issue is
// credit-limited so that in-flight words always have a free FIFO slot.
module instr_fetch_buffer #(
    parameter int DEPTH       = 4,
    parameter int FETCH_LIMIT = 63,
    parameter int PC_W        = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       fetch_en,
    output logic                       next_op,
    input  logic [31:0]                instr,
    instr_fetch_buffer_if.master       dec,
    output logic [$clog2(DEPTH):0]     buf_count,
    output logic                       fetch_done
);

    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ISS_W  = $clog2(FETCH_LIMIT + 1);

    localparam logic [ISS_W-1:0] ISS_MAX   = ISS_W'(FETCH_LIMIT);
    localparam logic [CNT_W:0]   CREDIT_MX = (CNT_W + 1)'(DEPTH);
    localparam logic [PC_W-1:0]  PC_STEP   = PC_W'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Request / capture bookkeeping
    logic [ISS_W-1:0]  issue_cnt;
    logic              pending;
    logic [PC_W-1:0]   pc;
    logic              issue_done;
    logic              issue_ok;

    // FIFO storage and control
    logic [DATA_W-1:0] fifo_instr [DEPTH];
    logic [PC_W-1:0]   fifo_pc    [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              head_vld;

    // Occupancy plus the word still in flight must leave room for one more.
    // Uses the registered count only, so a pop frees credit one cycle later.
    function automatic logic has_credit(input logic [CNT_W-1:0] occ,
                                        input logic             inflight);
        logic [CNT_W:0] used;
        used = {1'b0, occ} + {{CNT_W{1'b0}}, inflight};
        return used < CREDIT_MX;
    endfunction

    assign issue_done = (issue_cnt == ISS_MAX);
    assign issue_ok   = fetch_en && !issue_done && has_credit(count, pending);

    assign push     = pending;
    assign head_vld = (count != '0);
    assign pop      = head_vld && dec.dec_ready;

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and request pulse; requests only ever leave RUN
    always_comb begin
        state_nxt = state;
        next_op   = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (issue_done) begin
                    state_nxt = DRAIN;
                end else if (!fetch_en) begin
                    state_nxt = IDLE;
                end else begin
                    next_op = issue_ok;
                end
            end
            DRAIN: begin
                if (!pending) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- stage p0 -> p1: request issued, word returns next cycle ----
    // Track issued words, the in-flight flag and the PC of the next capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_cnt <= '0;
            pending   <= 1'b0;
            pc        <= '0;
        end else begin
            pending <= next_op;
            if (next_op) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (push) begin
                pc <= pc + PC_STEP;
            end
        end
    end

    // ---- stage p1 -> FIFO: returned word captured with its PC tag ----
    // FIFO payload; contents are meaningless unless covered by count
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_instr[wr_ptr] <= instr;
            fifo_pc[wr_ptr]    <= pc;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---- FIFO head -> decode ----
    // Head is shown straight from storage; forced to zero while empty so
    // stale entries never leak out after reset.
    assign dec.dec_valid = head_vld;
    assign dec.dec_instr = head_vld ? fifo_instr[rd_ptr] : '0;
    assign dec.dec_pc    = head_vld ? fifo_pc[rd_ptr]    : '0;

    assign buf_count  = count;
    assign fetch_done = (state == DONE);

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Testbench for instr_fetch_buffer with a sequential instruction memory model.
module tb_instr_fetch_buffer;

    localparam int DEPTH       = 4;
    localparam int FETCH_LIMIT = 63;
    localparam int PC_W        = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        next_op;
    logic [31:0] instr;
    logic [2:0]  buf_count;
    logic        fetch_done;
    logic        mem_reset_n;

    instr_fetch_buffer_if #(.PC_W(PC_W)) dif ();

    instr_fetch_buffer #(
        .DEPTH(DEPTH),
        .FETCH_LIMIT(FETCH_LIMIT),
        .PC_W(PC_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fetch_en(fetch_en),
        .next_op(next_op),
        .instr(instr),
        .dec(dif),
        .buf_count(buf_count),
        .fetch_done(fetch_done)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] exp_word(input int i);
        case (i % 3)
            0:       return 32'h00A00093;
            1:       return 32'h00108133;
            default: return 32'h00208203;
        endcase
    endfunction

    // Sequential instruction memory: one word per next_op, data next cycle
    assign mem_reset_n = ~reset;
    int mem_idx;
    always @(posedge clock or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            mem_idx <= 0;
            instr   <= '0;
        end else if (next_op) begin
            instr   <= exp_word(mem_idx);
            mem_idx <= mem_idx + 1;
        end
    end

    // Independent tracking of in-flight words and total issues
    logic tb_pend;
    int   issue_total;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            tb_pend     <= 1'b0;
            issue_total <= 0;
        end else begin
            tb_pend <= next_op;
            if (next_op) issue_total <= issue_total + 1;
        end
    end

    // Pop recorder and overflow / underflow watch
    logic [7:0]  pop_pc  [64];
    logic [31:0] pop_ins [64];
    int          pop_cnt = 0;
    logic        ovf_seen = 1'b0;
    logic        unf_seen = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            pop_cnt <= 0;
        end else begin
            if (dif.dec_valid && dif.dec_ready) begin
                if (pop_cnt < 64) begin
                    pop_pc[pop_cnt]  <= dif.dec_pc;
                    pop_ins[pop_cnt] <= dif.dec_instr;
                end
                pop_cnt <= pop_cnt + 1;
            end
            if (tb_pend && buf_count == 3'(DEPTH)) ovf_seen <= 1'b1;
            if (dif.dec_valid != (buf_count != 3'd0)) unf_seen <= 1'b1;
        end
    end

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fetch_en = 1'b0;
        dif.dec_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic        fen;
        logic        rdy;
        logic        nop;
        logic        vld;
        logic [7:0]  pc;
        logic [31:0] ins;
        logic [2:0]  cnt;
    } vec_t;

    function automatic vec_t mk(input logic fen, input logic rdy, input logic nop,
                                input logic vld, input logic [7:0] pc,
                                input logic [31:0] ins, input logic [2:0] cnt);
        vec_t v;
        v.fen = fen; v.rdy = rdy; v.nop = nop; v.vld = vld;
        v.pc = pc; v.ins = ins; v.cnt = cnt;
        return v;
    endfunction

    vec_t tbl [14];

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int   pulses;
        logic seen;
        logic found;
        int   bad;
        int   pops_at_done;
        logic [2:0] cnt_at_done;

        // Cycle-by-cycle expectations after reset release (cycle 0 = IDLE)
        tbl[0]  = mk(1, 1, 0, 0, 8'h00, 32'h00000000, 3'd0);
        tbl[1]  = mk(1, 1, 1, 0, 8'h00, 32'h00000000, 3'd0);
        tbl[2]  = mk(1, 1, 1, 0, 8'h00, 32'h00000000, 3'd0);
        tbl[3]  = mk(1, 1, 1, 1, 8'h00, 32'h00A00093, 3'd1);
        tbl[4]  = mk(1, 1, 1, 1, 8'h04, 32'h00108133, 3'd1);
        tbl[5]  = mk(1, 1, 1, 1, 8'h08, 32'h00208203, 3'd1);
        tbl[6]  = mk(1, 1, 1, 1, 8'h0C, 32'h00A00093, 3'd1);
        tbl[7]  = mk(1, 1, 1, 1, 8'h10, 32'h00108133, 3'd1);
        tbl[8]  = mk(1, 0, 1, 1, 8'h14, 32'h00208203, 3'd1);
        tbl[9]  = mk(1, 0, 1, 1, 8'h14, 32'h00208203, 3'd2);
        tbl[10] = mk(1, 0, 0, 1, 8'h14, 32'h00208203, 3'd3);
        tbl[11] = mk(1, 1, 0, 1, 8'h14, 32'h00208203, 3'd4);
        tbl[12] = mk(1, 1, 1, 1, 8'h18, 32'h00A00093, 3'd3);
        tbl[13] = mk(1, 1, 1, 1, 8'h1C, 32'h00108133, 3'd2);

        // Reset values, with fetch enabled and decode ready during reset
        reset = 1'b1;
        fetch_en = 1'b1;
        dif.dec_ready = 1'b1;
        @(negedge clock);
        chk("rst.next_op",    32'(next_op),       32'h0);
        chk("rst.dec_valid",  32'(dif.dec_valid), 32'h0);
        chk("rst.dec_instr",  dif.dec_instr,      32'h0);
        chk("rst.dec_pc",     32'(dif.dec_pc),    32'h0);
        chk("rst.buf_count",  32'(buf_count),     32'h0);
        chk("rst.fetch_done", 32'(fetch_done),    32'h0);

        // Table: first beats, steady state, stall with stable head, credit
        do_reset();
        for (int i = 0; i < 14; i++) begin
            fetch_en = tbl[i].fen;
            dif.dec_ready = tbl[i].rdy;
            @(negedge clock);
            chk($sformatf("t1[%0d].next_op", i),   32'(next_op),       32'(tbl[i].nop));
            chk($sformatf("t1[%0d].dec_valid", i), 32'(dif.dec_valid), 32'(tbl[i].vld));
            chk($sformatf("t1[%0d].dec_pc", i),    32'(dif.dec_pc),    32'(tbl[i].pc));
            chk($sformatf("t1[%0d].dec_instr", i), dif.dec_instr,      tbl[i].ins);
            chk($sformatf("t1[%0d].buf_count", i), 32'(buf_count),     32'(tbl[i].cnt));
            @(posedge clock); #1;
        end

        // Decode stalled from the start: exactly DEPTH requests, then resume
        do_reset();
        fetch_en = 1'b1;
        dif.dec_ready = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clock);
            if (next_op) pulses++;
            @(posedge clock); #1;
        end
        @(negedge clock);
        chk("t2.pulses",    32'(pulses),    32'd4);
        chk("t2.buf_count", 32'(buf_count), 32'd4);
        chk("t2.next_op",   32'(next_op),   32'd0);
        @(posedge clock); #1;
        dif.dec_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            if (k == 0) chk("t2.head_pc", 32'(dif.dec_pc), 32'h0);
            if (next_op) seen = 1'b1;
            @(posedge clock); #1;
        end
        chk("t2.resume", 32'(seen), 32'd1);

        // fetch_en dropped right after an issue: in-flight word still lands
        do_reset();
        fetch_en = 1'b1;
        dif.dec_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clock);
            if (next_op) found = 1'b1;
            @(posedge clock); #1;
        end
        chk("t3.first_issue", 32'(found), 32'd1);
        fetch_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("t3.idle_next_op[%0d]", k), 32'(next_op), 32'd0);
            @(posedge clock); #1;
        end
        fetch_en = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        chk("t3.enough_pops", 32'(pop_cnt >= 10), 32'd1);
        for (int i = 0; i < pop_cnt && i < 64; i++) begin
            chk($sformatf("t3.pc[%0d]", i),    32'(pop_pc[i]), 32'(i * 4));
            chk($sformatf("t3.instr[%0d]", i), pop_ins[i],     exp_word(i));
        end

        // Full run with decode always ready
        do_reset();
        fetch_en = 1'b1;
        dif.dec_ready = 1'b1;
        found = 1'b0;
        pops_at_done = 0;
        cnt_at_done = '0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clock);
            if (fetch_done) begin
                found = 1'b1;
                pops_at_done = pop_cnt;
                cnt_at_done = buf_count;
            end
            @(posedge clock); #1;
        end
        chk("t4.fetch_done",   32'(found),        32'd1);
        chk("t4.issues",       32'(issue_total),  32'd63);
        chk("t4.pops_at_done", 32'(pops_at_done), 32'd63);
        chk("t4.cnt_at_done",  32'(cnt_at_done),  32'd0);
        chk("t4.last_pc",      32'(pop_pc[62]),   32'h000000F8);
        chk("t4.last_instr",   pop_ins[62],       32'h00208203);
        repeat (5) @(posedge clock);
        #1;
        chk("t4.issues_after", 32'(issue_total), 32'd63);
        chk("t4.done_held",    32'(fetch_done),  32'd1);

        // Full run with random decode back-pressure
        do_reset();
        fetch_en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            dif.dec_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (fetch_done && buf_count == 3'd0) found = 1'b1;
            @(posedge clock); #1;
        end
        chk("t5.completed", 32'(found),       32'd1);
        chk("t5.issues",    32'(issue_total), 32'd63);
        chk("t5.pops",      32'(pop_cnt),     32'd63);
        bad = 0;
        for (int i = 0; i < 63; i++) begin
            if (pop_pc[i] !== 8'(i * 4) || pop_ins[i] !== exp_word(i)) bad++;
        end
        chk("t5.stream_errors", 32'(bad), 32'd0);

        // Reset mid-operation with three buffered words and one in flight
        do_reset();
        fetch_en = 1'b1;
        dif.dec_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clock);
            if (buf_count == 3'd3 && tb_pend) found = 1'b1;
            else begin
                @(posedge clock); #1;
            end
        end
        chk("t6.reached_state", 32'(found), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t6.next_op",    32'(next_op),       32'h0);
        chk("t6.dec_valid",  32'(dif.dec_valid), 32'h0);
        chk("t6.dec_instr",  dif.dec_instr,      32'h0);
        chk("t6.dec_pc",     32'(dif.dec_pc),    32'h0);
        chk("t6.buf_count",  32'(buf_count),     32'h0);
        chk("t6.fetch_done", 32'(fetch_done),    32'h0);
        @(posedge clock);
        @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        fetch_en = 1'b1;
        dif.dec_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clock); #1;
            if (pop_cnt >= 1) found = 1'b1;
        end
        chk("t6.popped_again", 32'(found),      32'd1);
        chk("t6.first_pc",     32'(pop_pc[0]),  32'h0);
        chk("t6.first_instr",  pop_ins[0],      32'h00A00093);

        chk("overflow_seen",  32'(ovf_seen), 32'd0);
        chk("underflow_seen", 32'(unf_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Fetch-side consumer of the sequential instruction memory.
- Pulses `next_op` to request words and captures each returned `instr` one cycle later.
- Tags every captured word with its byte PC and queues it in a small FIFO.
- Presents queued words to decode through a valid/ready handshake, which decouples decode stalls from memory fetch timing.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- FETCH_LIMIT, 63, number of words fetched before the block stops permanently (memory image size).
- PC_W, 8, width of the byte PC tag; PC = word_index*4, wraps modulo 2^PC_W.

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state. Top level drives the memory's `reset_n` from `~reset`.
- fetch_en  in  1  permits issuing new requests.
- next_op  out  1  request pulse to instruction memory; one word per high cycle.
- instr  in  32  memory data; valid in the cycle after a cycle with `next_op`=1.
- dec_valid  out  1  FIFO head valid.
- dec_ready  in  1  decode accepts head when `dec_valid` && `dec_ready`.
- dec_instr  out  32  head instruction.
- dec_pc  out  PC_W  head byte PC.
- buf_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- fetch_done  out  1  all FETCH_LIMIT words issued and captured.

Behaviour:
- Reset values:
  - `next_op`=0, `dec_valid`=0, `dec_instr`=0, `dec_pc`=0, `buf_count`=0, `fetch_done`=0.
  - Internal: `issue_cnt`=0, `pc`=0, `pending`=0, FSM=IDLE.
- FSM states:
  - IDLE → RUN when `fetch_en`=1.
  - RUN → IDLE when `fetch_en`=0.
  - RUN → DRAIN when the issue counter reaches FETCH_LIMIT.
  - DRAIN → DONE once `pending`=0.
  - DONE is terminal until reset.
- Issue rule, evaluated combinationally in RUN:
  - `next_op` = `fetch_en` && (`issue_cnt` < FETCH_LIMIT) && (`buf_count` + `pending` < DEPTH).
  - `next_op` is never asserted in IDLE, DRAIN or DONE.
- Capture:
  - `pending` <= `next_op` each cycle.
  - When `pending`=1, push {`instr`, `pc`} into the FIFO, then `pc` <= `pc`+4.
  - Latency is 1 cycle. Back-to-back `next_op` gives one push per cycle.
- Credit rule: a pop in the same cycle does not free issue credit until the next cycle. This conservative rule guarantees no push into a full FIFO. Overflow is impossible by construction; a bench assertion flags it.
- Pop:
  - Occurs on `dec_valid` && `dec_ready`.
  - `dec_instr`/`dec_pc` show the head combinationally from FIFO storage.
  - `dec_valid` = (`buf_count` != 0).
- Simultaneous push and pop: `buf_count` is unchanged and ordering is preserved.
- Push into an empty FIFO: the word is visible on `dec_valid` the following cycle. There is no same-cycle bypass.
- `fetch_en` deasserted while `pending`=1: the in-flight word is still captured. No new issue occurs.
- `dec_instr`/`dec_pc` hold stable while `dec_valid`=1 and `dec_ready`=0.
- Wrap behaviour:
  - `pc` wraps modulo 2^PC_W.
  - FIFO pointers wrap modulo DEPTH.
  - `issue_cnt` saturates at FETCH_LIMIT.
- `fetch_done`=1 in DONE. Buffered words remain poppable after `fetch_done` rises.
- Reset asserted mid-operation:
  - All state and FIFO contents are discarded immediately.
  - `next_op` drops asynchronously through the FSM reset.
  - The memory is reset in the same cycle via `reset_n`.

Test Plan:
- Reset, `fetch_en`=1, `dec_ready`=1, memory model → first beats (`dec_pc`, `dec_instr`):
  - (0x00, 0x00A00093)
  - (0x04, 0x00108133)
  - (0x08, 0x00208203)
  - (0x0C, 0x00A00093)
  - Steady state: one pop per cycle.
- `dec_ready`=0 from start, `fetch_en`=1 → exactly 4 `next_op` pulses. `buf_count` settles at 4, `next_op` stays 0. Raising `dec_ready` resumes issue within 2 cycles.
- `fetch_en` toggled low for 3 cycles right after an issue → the pending word is still captured. No `next_op` while low. PC sequence stays contiguous with no gap or duplicate.
- Run to completion with `dec_ready`=1 → 63 `next_op` pulses total. `fetch_done` rises after the 63rd capture. Last `dec_pc`=0xF8, last `dec_instr`=0x00208203.
- Random `dec_ready` with 50% duty over a full run → the popped stream equals the memory pattern in order, with no overflow or underflow assertion.
- Reset asserted with `buf_count`=3 and `pending`=1 → all outputs return to 0 immediately. After release the next word popped is PC 0x00, 0x00A00093.
